// File: rtl/key_debounce_pkg.sv
// Shared types and defaults for the multi-channel key debouncer.
package key_debounce_pkg;

  localparam int DEF_CH           = 4;
  localparam int DEF_DEBOUNCE_CYC = 5;
  localparam int DEF_LONG_CYC     = 50;
  localparam int DEF_CNT_W        = 4;

  // Per-channel debounce/press FSM.
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,  // stable released
    ST_PRESS_WAIT   = 3'd1,  // low seen, qualifying the press
    ST_PRESSED      = 3'd2,  // accepted press, hold timer running
    ST_LONG_HELD    = 3'd3,  // long press already reported
    ST_RELEASE_WAIT = 3'd4   // high seen, qualifying the release
  } kd_state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-FF synchroniser, debounce/long-press FSM and a
// wrapping press counter. All outputs come straight from flops.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_in,
  input  logic             cnt_clr,
  output logic             key_state,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int DB_W   = cnt_w(DEBOUNCE_CYC);
  localparam int HOLD_W = cnt_w(LONG_CYC);

  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYC);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC);

  logic              sync_q1;
  logic              sync_q2;
  logic              s;

  kd_state_t         state;
  kd_state_t         state_nxt;
  logic [DB_W-1:0]   db_cnt;
  logic [DB_W-1:0]   db_cnt_nxt;
  logic [DB_W-1:0]   db_inc;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_nxt;
  logic [HOLD_W-1:0] hold_inc;
  logic              from_long;
  logic              from_long_nxt;
  logic              press_nxt;
  logic              release_nxt;
  logic              long_nxt;

  assign s        = sync_q2;
  assign db_inc   = db_cnt + DB_W'(1);
  // Hold timer saturates so a very long hold never wraps into a second long_pulse.
  assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + HOLD_W'(1);

  // Two-flop synchroniser for the asynchronous, active-low key pin.
  // NOTE: both flops reset to 1 (released) so reset release never looks like a
  // falling edge; a key already held low is then seen as a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make sync_q2 take the old sync_q1,
      // giving two real flop stages rather than one.
      sync_q1 <= key_in;
      sync_q2 <= sync_q1;
    end
  end

  // Next-state and pulse decode for the debounce / long-press FSM.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_nxt     = state;
    db_cnt_nxt    = db_cnt;
    hold_cnt_nxt  = hold_cnt;
    from_long_nxt = from_long;
    press_nxt     = 1'b0;
    release_nxt   = 1'b0;
    long_nxt      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!s) begin
          state_nxt  = ST_PRESS_WAIT;
          db_cnt_nxt = DB_W'(1);
        end
      end

      ST_PRESS_WAIT: begin
        if (s) begin
          state_nxt = ST_IDLE;
        end else if (db_inc == DB_LAST) begin
          state_nxt    = ST_PRESSED;
          press_nxt    = 1'b1;
          hold_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_inc;
        end
      end

      ST_PRESSED: begin
        hold_cnt_nxt = hold_inc;
        if (s) begin
          state_nxt     = ST_RELEASE_WAIT;
          db_cnt_nxt    = DB_W'(1);
          from_long_nxt = 1'b0;
        end else if (hold_inc == HOLD_MAX) begin
          state_nxt = ST_LONG_HELD;
          long_nxt  = 1'b1;
        end
      end

      ST_LONG_HELD: begin
        if (s) begin
          state_nxt     = ST_RELEASE_WAIT;
          db_cnt_nxt    = DB_W'(1);
          from_long_nxt = 1'b1;
        end
      end

      ST_RELEASE_WAIT: begin
        // Hold timer keeps running so a release glitch does not restart it.
        hold_cnt_nxt = hold_inc;
        if (!s) begin
          state_nxt = from_long ? ST_LONG_HELD : ST_PRESSED;
        end else if (db_inc == DB_LAST) begin
          state_nxt   = ST_IDLE;
          release_nxt = 1'b1;
        end else begin
          db_cnt_nxt = db_inc;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state, counters and registered event outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      from_long     <= 1'b0;
      key_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_nxt;
      db_cnt        <= db_cnt_nxt;
      hold_cnt      <= hold_cnt_nxt;
      from_long     <= from_long_nxt;
      key_state     <= (state_nxt == ST_PRESSED) || (state_nxt == ST_LONG_HELD) ||
                       (state_nxt == ST_RELEASE_WAIT);
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
      long_pulse    <= long_nxt;
    end
  end

  // Wrapping press counter; a clear coinciding with a press pulse leaves 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      press_cnt <= '0;
    end else if (cnt_clr) begin
      press_cnt <= CNT_W'(press_pulse);
    end else if (press_pulse) begin
      press_cnt <= press_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/key_debounce_multi.sv
// CH independent key debouncers; this level only fans the packed vectors
// out to the per-channel instances and gathers their results back.
module key_debounce_multi
  import key_debounce_pkg::*;
#(
  parameter int CH           = DEF_CH,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int LONG_CYC     = DEF_LONG_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       key_in,
  input  logic [CH-1:0]       cnt_clr,
  output logic [CH-1:0]       key_state,
  output logic [CH-1:0]       press_pulse,
  output logic [CH-1:0]       release_pulse,
  output logic [CH-1:0]       long_pulse,
  output logic [CH*CNT_W-1:0] press_cnt
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .key_in        (key_in[i]),
      .cnt_clr       (cnt_clr[i]),
      .key_state     (key_state[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i]),
      .press_cnt     (press_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: doc/key_debounce_multi.md
# key_debounce_multi

Multi-channel debouncer and press-event detector for active-low mechanical keys. It is the parametrised successor to the single-key debounce/press counter. Each channel synchronises its raw key input, then filters bounce with a configurable stable-time window. It produces press, release and long-press pulses, a debounced level and a wrapping per-channel press counter. It sits between the board key pins and the control/display logic that consumes key events.

## Interface
- `CH`, 4: number of independent key channels (1..16)
- `DEBOUNCE_CYC`, 5: consecutive stable synchronised samples required to accept a level change (≥2)
- `LONG_CYC`, 50: cycles a key must stay pressed, counted from `press_pulse`, before `long_pulse` (> `DEBOUNCE_CYC`)
- `CNT_W`, 4: width of each press counter
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `key_in`  in  `CH`  raw key pins, active-low (0 = pressed), asynchronous to `clk`
- `cnt_clr`  in  `CH`  synchronous per-channel press-counter clear
- `key_state`  out  `CH`  debounced level, 1 = pressed
- `press_pulse`  out  `CH`  one-cycle pulse on an accepted press
- `release_pulse`  out  `CH`  one-cycle pulse on an accepted release
- `long_pulse`  out  `CH`  one-cycle pulse when a press reaches `LONG_CYC`
- `press_cnt`  out  `CH*CNT_W`  packed counters; channel i occupies bits [i*CNT_W +: CNT_W]

## Operation
- Per channel, a 2-FF synchroniser drives sample `s`. Both flops reset to 1 (released).
- Per-channel FSM states:
  - IDLE (stable released)
  - PRESS_WAIT
  - PRESSED
  - LONG_HELD
  - RELEASE_WAIT
- IDLE: `s`=0 → PRESS_WAIT, debounce counter = 1.
- PRESS_WAIT: while `s`=0, increment the counter. When the counter reaches `DEBOUNCE_CYC`, go to PRESSED and pulse `press_pulse`. If `s`=1 at any point, return to IDLE with no pulse.
- PRESSED: the hold counter runs from the press. `s`=1 → RELEASE_WAIT. Hold counter reaching `LONG_CYC` → LONG_HELD with a single `long_pulse`. There is no auto-repeat.
- LONG_HELD: `s`=1 → RELEASE_WAIT.
- RELEASE_WAIT: debounce is symmetric to PRESS_WAIT. On acceptance, go to IDLE and pulse `release_pulse`. If `s`=0 before acceptance, return to the originating state (PRESSED or LONG_HELD). The hold counter keeps running; `long_pulse` may still fire from PRESSED.
- `key_state` = 1 in PRESSED, LONG_HELD and RELEASE_WAIT.
- `press_cnt[i]` increments on `press_pulse[i]` and wraps modulo 2^`CNT_W` (15 → 0).
- `cnt_clr[i]` alone sets the counter to 0. If `cnt_clr[i]` and `press_pulse[i]` fall in the same cycle, the counter becomes 1.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.
- Hold counter saturates at `LONG_CYC`; widths are `$clog2(LONG_CYC+1)` and `$clog2(DEBOUNCE_CYC+1)`.

## Timing
- On reset, all states go to IDLE and all counters clear. Every output is 0, including `press_cnt`.
- Reset asserted mid-operation aborts any pending pulse. No `release_pulse` is emitted for a key that was pressed at reset.
- A key held low through reset release is seen as a new press. `press_pulse` follows after the normal latency.
- Latency: count edge 1 as the first rising edge sampling `key_in`=0. `press_pulse` is high in the cycle following edge `2+DEBOUNCE_CYC`; with defaults, edge 7. Release latency is identical.
- `long_pulse` is asserted exactly `LONG_CYC` cycles after `press_pulse`, provided the release is not yet accepted.
- `press_pulse`, `release_pulse` and `long_pulse` each last exactly 1 cycle. `press_pulse` and `release_pulse` are never both high on one channel. All outputs are registered.

## Structure
- Package `key_debounce_pkg` holds:
  - the FSM state enum `kd_state_t`
  - the default parameter constants
  - a `cnt_w()` width helper
- Sub-module `key_debounce_ch` (one channel: synchroniser, FSM, counters, press counter) is instantiated `CH` times in a generate loop. The top level only packs and unpacks vectors.

## Test plan
- Clean press: ch0 low for 200 ns, 20 ns clock, defaults → `press_pulse[0]` at edge 7, `key_state[0]`=1, `press_cnt[0]`=1. Release gives `release_pulse[0]` 7 edges after rising.
- Bounce: ch1 low 3 cycles, high 1, low 10 → only one `press_pulse[1]`, timed from the second falling edge. A 3-cycle release glitch gives no `release_pulse`.
- Long press: ch2 held low 80 cycles, `LONG_CYC`=50 → `long_pulse[2]` exactly 50 cycles after `press_pulse[2]`, exactly once. Release then gives `release_pulse[2]`.
- Wrap and clear: 16 clean presses on ch3 with `CNT_W`=4 → `press_cnt[3]`=0. `cnt_clr[3]` coincident with the 17th `press_pulse` → 1.
- Parallel channels: all 4 keys pressed on the same edge → four simultaneous `press_pulse` bits. Independent releases give independent `release_pulse` bits.
- Reset mid-press: assert `rst` while ch0 is in PRESSED → outputs 0 immediately. Key still low after reset → new `press_pulse` after 7 edges, `press_cnt[0]`=1.
